// File: rtl/leaf_stream_bridge_if.sv
// leaf_stream_bridge_if -- stream bundle between a leaf wrapper and its operator.
//   Leaf -> operator : dout_leaf_interface2user / vld_interface2user / ack_user2interface
//                      in_tdata / in_tvalid / in_tready
//   Operator -> leaf : out_tdata / out_tvalid / out_tready
//                      din_leaf_user2interface / vld_user2interface / ack_interface2user
//   Channel i of every packed bus sits at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
//   slave  : the bridge side.
//   master : the environment (leaf wrapper plus operator).
`timescale 1ns/1ps
interface leaf_stream_bridge_if #(
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_IN_PORTS  = 1,
   parameter int NUM_OUT_PORTS = 1
);
   logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
   logic [NUM_IN_PORTS-1:0]               vld_interface2user;
   logic [NUM_IN_PORTS-1:0]               ack_user2interface;
   logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata;
   logic [NUM_IN_PORTS-1:0]               in_tvalid;
   logic [NUM_IN_PORTS-1:0]               in_tready;
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata;
   logic [NUM_OUT_PORTS-1:0]              out_tvalid;
   logic [NUM_OUT_PORTS-1:0]              out_tready;
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
   logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
   logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

   modport slave (
      input  dout_leaf_interface2user, vld_interface2user, in_tready,
             out_tdata, out_tvalid, ack_interface2user,
      output ack_user2interface, in_tdata, in_tvalid,
             out_tready, din_leaf_user2interface, vld_user2interface
   );

   modport master (
      output dout_leaf_interface2user, vld_interface2user, in_tready,
             out_tdata, out_tvalid, ack_interface2user,
      input  ack_user2interface, in_tdata, in_tvalid,
             out_tready, din_leaf_user2interface, vld_user2interface
   );
endinterface

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge -- buffers every leaf<->operator stream channel through its
// own FIFO and sequences the operator with an IDLE/RUN/DRAIN controller.
// Ports:
//   clk, reset     : sole clock, asynchronous active-high reset
//   ap_start       : run request (START_MODE=1 only)
//   running        : high in RUN or DRAIN
//   user_ap_start  : operator start, high only in RUN
//   user_ap_done   : operator done, honoured only in RUN
//   word_count     : per-output-channel transfer tally, 32 bits per channel
//   bus            : leaf_stream_bridge_if.slave stream bundle
// Optional feature: define LEAF_STREAM_BRIDGE_CNT_EN to build the word counters;
// otherwise word_count is tied to zero.
`timescale 1ns/1ps

// Single-clock FIFO. Head word comes straight from the storage registers, so a
// word written at edge N is visible right after that edge. Ready depends only
// on pointers and the enable flop, never on the read-side ready.
module leaf_stream_bridge_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             full, empty, push, pop;

   // Extra MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_ready = en & ~full;
   assign rd_valid = ~empty;
   assign rd_data  = mem[rd_ptr[AW-1:0]];
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

module leaf_stream_bridge #(
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_IN_PORTS  = 1,
   parameter int NUM_OUT_PORTS = 1,
   parameter int FIFO_DEPTH    = 4,
   parameter int START_MODE    = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ap_start,
   output logic                       running,
   output logic                       user_ap_start,
   input  logic                       user_ap_done,
   output logic [NUM_OUT_PORTS*32-1:0] word_count,
   leaf_stream_bridge_if.slave        bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0] state, state_nxt;
   logic       en;

   logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata_v;
   logic [NUM_IN_PORTS-1:0]               in_tvalid_v;
   logic [NUM_IN_PORTS-1:0]               ack_v;
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_v;
   logic [NUM_OUT_PORTS-1:0]              vld_u_v;
   logic [NUM_OUT_PORTS-1:0]              out_tready_v;

   // Holds every ready low while reset is asserted and releases them on the
   // first edge afterwards, without a combinational path from reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) en <= 1'b0;
      else       en <= 1'b1;
   end

   for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
      leaf_stream_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .wr_data  (bus.dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .wr_valid (bus.vld_interface2user[i]),
         .wr_ready (ack_v[i]),
         .rd_data  (in_tdata_v[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .rd_valid (in_tvalid_v[i]),
         .rd_ready (bus.in_tready[i])
      );
   end

   for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
      leaf_stream_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .wr_data  (bus.out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .wr_valid (bus.out_tvalid[j]),
         .wr_ready (out_tready_v[j]),
         .rd_data  (din_v[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .rd_valid (vld_u_v[j]),
         .rd_ready (bus.ack_interface2user[j])
      );
   end

   assign bus.in_tdata                = in_tdata_v;
   assign bus.in_tvalid               = in_tvalid_v;
   assign bus.ack_user2interface      = ack_v;
   assign bus.din_leaf_user2interface = din_v;
   assign bus.vld_user2interface      = vld_u_v;
   assign bus.out_tready              = out_tready_v;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (START_MODE == 0 || ap_start) state_nxt = ST_RUN;
         ST_RUN:   if (user_ap_done)                state_nxt = ST_DRAIN;
         ST_DRAIN: if (~|vld_u_v)                   state_nxt = ST_IDLE;
         default:                                   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   assign running       = (state == ST_RUN) || (state == ST_DRAIN);
   assign user_ap_start = (state == ST_RUN);

`ifdef LEAF_STREAM_BRIDGE_CNT_EN
   logic [31:0] cnt [NUM_OUT_PORTS];
   logic        run_start;

   assign run_start = (state == ST_IDLE) && (state_nxt == ST_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) cnt[j] <= '0;
      end else begin
         for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
            if (run_start)
               cnt[j] <= '0;
            else if (vld_u_v[j] && bus.ack_interface2user[j])
               cnt[j] <= cnt[j] + 32'd1;
         end
      end
   end

   always_comb begin
      word_count = '0;
      for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) word_count[j*32 +: 32] = cnt[j];
   end
`else
   assign word_count = '0;
`endif
endmodule

// File: doc/leaf_stream_bridge.md
LEAF_STREAM_BRIDGE -- requirements
Module: leaf_stream_bridge

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32: width of one stream word.
REQ-002 SHALL have parameter NUM_IN_PORTS, default 1: number of leaf-to-user channels (1..8).
REQ-003 SHALL have parameter NUM_OUT_PORTS, default 1: number of user-to-leaf channels (1..8).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: per-channel buffer depth (power of 2, 2..64).
REQ-005 SHALL have parameter START_MODE, default 0: 0 = operator starts free-running after reset, 1 = operator starts on ap_start.
REQ-006 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: ap_start  in  1  run request (used when START_MODE=1); running  out  1  high in RUN or DRAIN.
REQ-008 SHALL have ports: dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  leaf data; vld_interface2user  in  NUM_IN_PORTS  leaf valid; ack_user2interface  out  NUM_IN_PORTS  leaf-side ready.
REQ-009 SHALL have ports: in_tdata  out  NUM_IN_PORTS*PAYLOAD_BITS; in_tvalid  out  NUM_IN_PORTS; in_tready  in  NUM_IN_PORTS  (operator input streams).
REQ-010 SHALL have ports: out_tdata  in  NUM_OUT_PORTS*PAYLOAD_BITS; out_tvalid  in  NUM_OUT_PORTS; out_tready  out  NUM_OUT_PORTS  (operator output streams).
REQ-011 SHALL have ports: din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS; vld_user2interface  out  NUM_OUT_PORTS; ack_interface2user  in  NUM_OUT_PORTS  (leaf return path).
REQ-012 SHALL have ports: user_ap_start  out  1; user_ap_done  in  1; word_count  out  NUM_OUT_PORTS*32  per-output-channel word tally.

Function
REQ-013 Channel i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS] of every packed bus.
REQ-014 Every channel, both directions, SHALL pass through an independent FIFO of FIFO_DEPTH entries; transfer occurs on a cycle where valid and ready/ack are both high.
REQ-015 ack_user2interface[i] and out_tready[j] SHALL equal "FIFO not full"; in_tvalid and vld_user2interface SHALL equal "FIFO not empty"; read data SHALL be the FIFO head, registered.
REQ-016 Latency: a word written in cycle N SHALL be visible at the FIFO output in cycle N+1; no combinational path from any ready input to any ready output.
REQ-017 Simultaneous push and pop on a full FIFO SHALL be refused (not full is required to push); push and pop on a non-empty, non-full FIFO SHALL keep occupancy unchanged.
REQ-018 Pointers SHALL wrap modulo FIFO_DEPTH with one extra bit distinguishing full from empty; full throughput (one word/cycle) SHALL be sustained.
REQ-019 Control FSM states: IDLE, RUN, DRAIN; user_ap_start = 1 only in RUN.
REQ-020 IDLE->RUN: on the first cycle after reset when START_MODE=0; on ap_start=1 when START_MODE=1.
REQ-021 RUN->DRAIN on user_ap_done=1; DRAIN->IDLE when every output FIFO is empty; with START_MODE=0, IDLE->RUN again the next cycle.
REQ-022 ap_start in RUN or DRAIN SHALL be ignored; user_ap_done outside RUN SHALL be ignored.
REQ-023 FIFOs SHALL accept and deliver data in every state.

Reset
REQ-024 Reset SHALL asynchronously clear all FIFO pointers, set FSM to IDLE, and drive all valid/ready outputs, user_ap_start, running and word_count to 0.
REQ-025 Reset mid-transfer SHALL discard all buffered words; no word SHALL appear after deassertion unless newly pushed.

Configuration
REQ-026 With macro LEAF_STREAM_BRIDGE_CNT_EN defined, word_count[j] SHALL increment (wrapping at 2^32) on every transfer out of output channel j, clearing on IDLE->RUN.
REQ-027 Without LEAF_STREAM_BRIDGE_CNT_EN, word_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-028 NUM_IN_PORTS=2, FIFO_DEPTH=4, in_tready=0, push 5 words on ch1 -> ack_user2interface[1] low after 4th word, 5th held; ch0 unaffected.
REQ-029 Stream 0x00..0x3F continuous on ch0 with ready=1 -> output order identical, one word/cycle after 1-cycle latency, no bubbles.
REQ-030 START_MODE=1: hold ap_start=0 10 cycles -> user_ap_start=0; pulse ap_start -> user_ap_start=1 next cycle; ap_start again in RUN -> no effect.
REQ-031 user_ap_done pulse with 3 words buffered, ack_interface2user=1 -> DRAIN for 3 cycles, then IDLE, running=0.
REQ-032 Assert reset with FIFOs half full -> all valids 0 immediately; after release, no stale data emitted.
REQ-033 CNT_EN defined, 100 words out ch0 -> word_count[31:0]=100; restart -> 0.
